// File: rtl/count_display_if.sv
// Bundle between the 4-bit counter and the seven-segment display driver.
//   value : counter value, synchronous to clk (driven by the counter side)
//   an    : digit anodes, active-low, an[0] is the rightmost digit
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low
interface count_display_if;
    logic [3:0] value;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    // Counter / board side: supplies value, observes the display pins.
    modport master (
        output value,
        input  an,
        input  seg,
        input  dp
    );

    // Display driver side.
    modport slave (
        input  value,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/count_display_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver for the LED counter.
// Slot 0 shows the ones digit, slot 1 the tens digit (leading zero blanked),
// slot 2 the value in hex, slot 3 is always dark. The decimal point of slot 0
// flashes for FLASH_CYCLES after every change of the counter value.
//   clk     : board clock
//   clear_n : asynchronous active-low reset
//   bus     : value in; an/seg/dp out (all registered)
module count_display_driver #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned FLASH_CYCLES = 25000000
) (
    input  logic            clk,
    input  logic            clear_n,
    count_display_if.slave  bus
);

    localparam int unsigned TICK_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned FLASH_W = $clog2(FLASH_CYCLES + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_CYCLES - 1);
    localparam logic [TICK_W-1:0]  BLANK_END  = TICK_W'(BLANK_CYCLES);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

    logic [3:0]         val_q;
    logic [3:0]         val_prev;
    logic [3:0]         disp_val;
    logic [TICK_W-1:0]  tick;
    logic [1:0]         idx;
    logic [FLASH_W-1:0] flash_cnt;

    logic [3:0]         an_q;
    logic [6:0]         seg_q;
    logic               dp_q;

    logic               changed;
    logic               tick_wrap;
    logic               tens;
    logic [3:0]         ones;
    logic [3:0]         slot_digit;
    logic               slot_lit;
    logic               in_blank;
    logic [3:0]         an_d;
    logic [6:0]         seg_d;
    logic               dp_d;

    // Active-low segment pattern for one hex digit.
    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h7F;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign changed   = (val_q != val_prev);
    assign tick_wrap = (tick == TICK_LAST);
    assign tens      = (disp_val >= 4'd10);
    assign ones      = disp_val - (tens ? 4'd10 : 4'd0);
    assign in_blank  = (tick < BLANK_END);

    // Slot content selection and next output values.
    always_comb begin
        slot_digit = 4'd0;
        slot_lit   = 1'b0;
        case (idx)
            2'd0: begin
                slot_digit = ones;
                slot_lit   = 1'b1;
            end
            2'd1: begin
                slot_digit = 4'd1;
                slot_lit   = tens;
            end
            2'd2: begin
                slot_digit = disp_val;
                slot_lit   = 1'b1;
            end
            default: begin
                slot_digit = 4'd0;
                slot_lit   = 1'b0;
            end
        endcase

        an_d  = 4'b1111;
        seg_d = slot_lit ? hex_seg(slot_digit) : 7'h7F;
        dp_d  = 1'b1;
        if (slot_lit && !in_blank) begin
            an_d = ~(4'b0001 << idx);
            dp_d = !((flash_cnt != '0) && (idx == 2'd0));
        end
    end

    // Input capture, one-cycle history for change detection.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            val_q    <= 4'd0;
            val_prev <= 4'd0;
        end else begin
            val_q    <= bus.value;
            val_prev <= val_q;
        end
    end

    // Scan timing; the displayed value only moves at the slot3->slot0 boundary.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            tick     <= '0;
            idx      <= 2'd0;
            disp_val <= 4'd0;
        end else if (tick_wrap) begin
            tick <= '0;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
                disp_val <= val_q;
            end
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

    // Decimal-point flash: restart on every change, count down and stick at zero.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            flash_cnt <= '0;
        end else if (changed) begin
            flash_cnt <= FLASH_LOAD;
        end else if (flash_cnt != '0) begin
            flash_cnt <= flash_cnt - FLASH_W'(1);
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver with small scan parameters.
// A reference model predicts an/seg/dp from the edge index since reset and the
// history of sampled values; a compare process checks every cycle, and a set
// of hand-computed expectations pins specific points of the scan.
module tb_count_display_driver;

    localparam int D = 8;    // DIGIT_CYCLES
    localparam int B = 2;    // BLANK_CYCLES
    localparam int F = 20;   // FLASH_CYCLES
    localparam int FRAME = 4 * D;

    logic clk;
    logic clear_n;
    logic run_chk;

    int checks;
    int errors;

    count_display_if bus ();

    count_display_driver #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B),
        .FLASH_CYCLES (F)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter since reset release and the value sampled at each edge.
    int         k;
    logic [3:0] vq [0:8191];

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            k     = 0;
            vq[0] = 4'd0;
        end else begin
            k     = k + 1;
            vq[k] = bus.value;
        end
    end

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Value shown during state s: the sample taken just before the latest frame boundary.
    function automatic logic [3:0] m_disp(input int s);
        int b;
        b = (s / FRAME) * FRAME;
        return (b == 0) ? 4'd0 : vq[b - 1];
    endfunction

    // Flash is live in state s if a value change was seen within the last F states.
    function automatic bit m_flash(input int s);
        for (int c = s - F; c < s; c++) begin
            if (c >= 1 && vq[c] != vq[c - 1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected outputs after kk edges (outputs reflect state kk-1).
    task automatic model_out(input int kk, output logic [3:0] e_an, output logic [6:0] e_seg,
                             output logic e_dp, output bit seg_valid);
        int s, t, id, dv, digit;
        bit show, lit;
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1; seg_valid = 1'b1;
        if (kk > 0) begin
            s  = kk - 1;
            t  = s % D;
            id = (s / D) % 4;
            dv = int'(m_disp(s));
            show = 1'b0; digit = 0;
            case (id)
                0: begin show = 1'b1; digit = dv % 10; end
                1: begin show = (dv >= 10); digit = 1; end
                2: begin show = 1'b1; digit = dv; end
                default: show = 1'b0;
            endcase
            lit = show && (t >= B);
            seg_valid = (t >= B);
            if (lit) e_an = ~(4'b0001 << id);
            if (show) e_seg = seg_tbl[digit];
            e_dp = !(lit && id == 0 && m_flash(s));
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        bit         sv;
        if (run_chk && clear_n) begin
            model_out(k, e_an, e_seg, e_dp, sv);
            chk("an", {4'h0, bus.an}, {4'h0, e_an});
            chk("dp", {7'h0, bus.dp}, {7'h0, e_dp});
            if (sv) chk("seg", {1'b0, bus.seg}, {1'b0, e_seg});
        end
    end

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (k != target) begin
            errors++;
            $display("FAIL run_to actual_k=%0d required_k=%0d", k, target);
        end
    endtask

    task automatic lit(input int at, input string name, input logic [3:0] an_e,
                       input logic [6:0] seg_e, input bit check_seg, input logic dp_e, input bit check_dp);
        run_to(at);
        chk({name, "_an"}, {4'h0, bus.an}, {4'h0, an_e});
        if (check_seg) chk({name, "_seg"}, {1'b0, bus.seg}, {1'b0, seg_e});
        if (check_dp)  chk({name, "_dp"}, {7'h0, bus.dp}, {7'h0, dp_e});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        checks    = 0;
        errors    = 0;
        run_chk   = 1'b0;
        clear_n   = 1'b0;
        bus.value = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_an", {4'h0, bus.an}, 8'h0F);
        chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
        chk("rst_dp", {7'h0, bus.dp}, 8'h01);

        // Static value 7.
        bus.value = 4'd7;
        clear_n   = 1'b1;
        run_chk   = 1'b1;
        lit(33, "v7_s0_blank", 4'b1111, 7'h00, 1'b0, 1'b1, 1'b0);
        lit(36, "v7_s0",       4'b1110, 7'h78, 1'b1, 1'b1, 1'b1);
        lit(44, "v7_s1",       4'b1111, 7'h00, 1'b0, 1'b1, 1'b1);
        lit(51, "v7_s2",       4'b1011, 7'h78, 1'b1, 1'b1, 1'b0);
        lit(59, "v7_s3",       4'b1111, 7'h00, 1'b0, 1'b1, 1'b1);

        // Value 13 with flash.
        run_to(64);
        bus.value = 4'd13;
        lit(66, "v13_dp_blank", 4'b1111, 7'h00, 1'b0, 1'b1, 1'b1);
        lit(67, "v13_dp_on",    4'b1110, 7'h78, 1'b1, 1'b0, 1'b1);
        lit(99, "v13_s0",       4'b1110, 7'h30, 1'b1, 1'b1, 1'b0);
        lit(107, "v13_s1",      4'b1101, 7'h79, 1'b1, 1'b1, 1'b0);
        lit(115, "v13_s2",      4'b1011, 7'h21, 1'b1, 1'b1, 1'b0);

        // Mid-frame change 4 -> 5 during slot 1.
        run_to(128);
        bus.value = 4'd4;
        run_to(170);
        bus.value = 4'd5;
        lit(179, "mid_s2_old", 4'b1011, 7'h19, 1'b1, 1'b1, 1'b0);
        lit(195, "mid_s0_new", 4'b1110, 7'h12, 1'b1, 1'b1, 1'b0);

        // Back-to-back changes restart the flash.
        run_to(200);
        bus.value = 4'd6;
        run_to(205);
        bus.value = 4'd7;

        // Wrap 15 -> 0.
        run_to(240);
        bus.value = 4'd15;
        run_to(290);
        bus.value = 4'd0;
        lit(293, "wrap_dp",  4'b1110, 7'h00, 1'b0, 1'b0, 1'b1);
        lit(323, "wrap_s0",  4'b1110, 7'h40, 1'b1, 1'b1, 1'b0);
        lit(331, "wrap_s1",  4'b1111, 7'h00, 1'b0, 1'b1, 1'b0);
        lit(339, "wrap_s2",  4'b1011, 7'h40, 1'b1, 1'b1, 1'b0);

        // Randomized value activity, mixing counter-like steps and arbitrary jumps.
        while (k < 2200) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 0) bus.value = bus.value + 4'd1;
                else                           bus.value = 4'($urandom_range(0, 15));
            end
        end

        // Reset mid-scan while slot 2 is on the outputs.
        guard = 0;
        while (((k - 1) / D) % 4 != 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #2;
        clear_n = 1'b0;
        #1;
        chk("midrst_an", {4'h0, bus.an}, 8'h0F);
        chk("midrst_seg", {1'b0, bus.seg}, 8'h7F);
        chk("midrst_dp", {7'h0, bus.dp}, 8'h01);
        bus.value = 4'd0;
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        lit(2, "rel_k2", 4'b1111, 7'h00, 1'b0, 1'b1, 1'b1);
        lit(3, "rel_k3", 4'b1110, 7'h40, 1'b1, 1'b1, 1'b1);

        while (k < 400) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) bus.value = 4'($urandom_range(0, 15));
        end

        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
